// File: rtl/edge_detect_gate.sv
`timescale 1ns/1ps
// Edge pulse generator: compares the sampled level against a one-cycle-old copy.
// Latency: 0 cycles with SYNC_STAGES=0 (combinational), else SYNC_STAGES clock edges.
// Backpressure: none; free-running pulse output, no handshake.
module edge_detect_gate #(
    parameter int SYNC_STAGES = 0,  // 0..3 synchronizer flops ahead of the gate
    parameter int EDGE_MODE   = 0   // 0 rising, 1 falling, 2 both; others act as rising
) (
    input  logic clk_amisha,
    input  logic reset_amisha,
    input  logic level_amisha,
    output logic tick_amisha
);

    // Out-of-range modes collapse onto the plain rising-edge gate.
    localparam int MODE = ((EDGE_MODE == 1) || (EDGE_MODE == 2)) ? EDGE_MODE : 0;

    // The only state is the delayed copy of the sampled level.
    typedef enum logic {
        ZERO = 1'b0,
        ONE  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   s;          // sampled level seen by the gate
    logic   delay_reg;  // level as it was at the previous rising edge

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = level_amisha;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Shift the raw level through the synchronizer chain.
            always_ff @(posedge clk_amisha or negedge reset_amisha) begin
                if (!reset_amisha) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= level_amisha;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign delay_reg = (state == ONE);

    // Delay register: captures the sampled level every rising edge.
    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            state <= ZERO;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state follows the sample; tick is a Mealy decode held low during reset.
    always_comb begin
        state_nxt   = state;
        tick_amisha = 1'b0;
        state_nxt   = s ? ONE : ZERO;
        if (reset_amisha) begin
            case (MODE)
                1:       tick_amisha = !s && delay_reg;
                2:       tick_amisha = s ^ delay_reg;
                default: tick_amisha = s && !delay_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_detect_gate.sv
`timescale 1ns/1ps
// Bench for edge_detect_gate: several parameterisations share clock, reset and level.
// Latency: checks sample 1 ns after stimulus changes, away from rising edges.
// Backpressure: not applicable.
module tb_edge_detect_gate;

    logic clk;
    logic rst_n;
    logic level;

    logic t_r0;  // rising, no sync
    logic t_f0;  // falling, no sync
    logic t_b0;  // both, no sync
    logic t_x0;  // mode 3 (acts as rising), no sync
    logic t_b1;  // both, 1 stage
    logic t_r2;  // rising, 2 stages
    logic t_f3;  // falling, 3 stages

    edge_detect_gate #(.SYNC_STAGES(0), .EDGE_MODE(0)) u_r0 (
        .clk_amisha(clk), .reset_amisha(rst_n), .level_amisha(level), .tick_amisha(t_r0));
    edge_detect_gate #(.SYNC_STAGES(0), .EDGE_MODE(1)) u_f0 (
        .clk_amisha(clk), .reset_amisha(rst_n), .level_amisha(level), .tick_amisha(t_f0));
    edge_detect_gate #(.SYNC_STAGES(0), .EDGE_MODE(2)) u_b0 (
        .clk_amisha(clk), .reset_amisha(rst_n), .level_amisha(level), .tick_amisha(t_b0));
    edge_detect_gate #(.SYNC_STAGES(0), .EDGE_MODE(3)) u_x0 (
        .clk_amisha(clk), .reset_amisha(rst_n), .level_amisha(level), .tick_amisha(t_x0));
    edge_detect_gate #(.SYNC_STAGES(1), .EDGE_MODE(2)) u_b1 (
        .clk_amisha(clk), .reset_amisha(rst_n), .level_amisha(level), .tick_amisha(t_b1));
    edge_detect_gate #(.SYNC_STAGES(2), .EDGE_MODE(0)) u_r2 (
        .clk_amisha(clk), .reset_amisha(rst_n), .level_amisha(level), .tick_amisha(t_r2));
    edge_detect_gate #(.SYNC_STAGES(3), .EDGE_MODE(1)) u_f3 (
        .clk_amisha(clk), .reset_amisha(rst_n), .level_amisha(level), .tick_amisha(t_f3));

    int n_checks = 0;
    int n_pass   = 0;

    // 100 ns clock, first rising edge at 50 ns.
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t ns", tag, got, exp, $time);
    endtask

    // Reference: history of level samples taken at rising edges since reset.
    // smp[k] is the level seen k+1 edges ago (0 if reset since then).
    logic [3:0] smp = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) smp <= '0;
        else        smp <= {smp[2:0], level};
    end

    // Level as seen through n stages now, versus one edge older; pulse per mode.
    function automatic logic ref_tick(input int mode, input int n);
        logic now_v;
        logic old_v;
        now_v = (n == 0) ? level : smp[n-1];
        old_v = smp[n];
        if (!rst_n) return 1'b0;
        case (mode)
            1:       return (now_v == 1'b0) && (old_v == 1'b1);
            2:       return now_v != old_v;
            default: return (now_v == 1'b1) && (old_v == 1'b0);
        endcase
    endfunction

    task automatic check_all();
        chk("r0", t_r0, ref_tick(0, 0));
        chk("f0", t_f0, ref_tick(1, 0));
        chk("b0", t_b0, ref_tick(2, 0));
        chk("x0", t_x0, ref_tick(0, 0));
        chk("b1", t_b1, ref_tick(2, 1));
        chk("r2", t_r2, ref_tick(0, 2));
        chk("f3", t_f3, ref_tick(1, 3));
    endtask

    task automatic at(input longint t);
        if ($time < t) #(t - $time);
    endtask

    initial begin
        rst_n = 1'b0;
        level = 1'b0;

        // Reset and release with level low.
        at(10);   chk("rst_r0", t_r0, 1'b0); chk("rst_b0", t_b0, 1'b0);
                  chk("rst_dreg", u_r0.delay_reg, 1'b0);
        at(100);  rst_n = 1'b1;
        at(120);  chk("rel_r0", t_r0, 1'b0); chk("rel_dreg", u_r0.delay_reg, 1'b0);

        // Rising at 200: pulse until the 250 edge.
        at(200);  level = 1'b1;
        at(201);  chk("up_r0", t_r0, 1'b1); chk("up_b0", t_b0, 1'b1);
                  chk("up_f0", t_f0, 1'b0); chk("up_x0", t_x0, 1'b1);
        at(249);  chk("up_r0_hold", t_r0, 1'b1);
        at(251);  chk("up_r0_end", t_r0, 1'b0); chk("up_b0_end", t_b0, 1'b0);
                  chk("up_dreg", u_r0.delay_reg, 1'b1);
        at(299);  chk("hi_r0", t_r0, 1'b0);

        // Falling at 300: only falling/both modes pulse.
        at(300);  level = 1'b0;
        at(301);  chk("dn_r0", t_r0, 1'b0); chk("dn_f0", t_f0, 1'b1); chk("dn_b0", t_b0, 1'b1);
        at(349);  chk("dn_b0_hold", t_b0, 1'b1);
        at(351);  chk("dn_b0_end", t_b0, 1'b0); chk("dn_f0_end", t_f0, 1'b0);

        // Rising at 400, reset mid-pulse at 420, release at 430 with level high.
        at(400);  level = 1'b1;
        at(401);  chk("up2_r0", t_r0, 1'b1); chk("up2_b0", t_b0, 1'b1);
        at(420);  rst_n = 1'b0;
        at(421);  chk("mid_rst_r0", t_r0, 1'b0); chk("mid_rst_b0", t_b0, 1'b0);
                  chk("mid_rst_dreg", u_r0.delay_reg, 1'b0);
        at(430);  rst_n = 1'b1;
        at(431);  chk("rel_hi_r0", t_r0, 1'b1); chk("rel_hi_b0", t_b0, 1'b1);
        at(449);  chk("rel_hi_r0_hold", t_r0, 1'b1);
        at(451);  chk("rel_hi_r0_end", t_r0, 1'b0); chk("rel_hi_b0_end", t_b0, 1'b0);

        // Two-stage synchronizer: rise at 1200 gives a tick from 1350 to 1450.
        at(1000); rst_n = 1'b0; level = 1'b0;
        at(1100); rst_n = 1'b1;
        at(1200); level = 1'b1;
        at(1201); chk("s2_r2_early", t_r2, 1'b0);
        at(1251); chk("s2_r2_stage0", t_r2, 1'b0);
        at(1349); chk("s2_r2_pre", t_r2, 1'b0);
        at(1351); chk("s2_r2_on", t_r2, 1'b1);
        at(1449); chk("s2_r2_hold", t_r2, 1'b1);
        at(1451); chk("s2_r2_off", t_r2, 1'b0);
        check_all();

        // Level held constant: no ticks anywhere.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1 check_all();
        end

        // Randomized level activity, narrow glitches and async reset pulses.
        for (int c = 0; c < 300; c++) begin
            for (int h = 0; h < 2; h++) begin
                if (h == 0) @(posedge clk);
                else        @(negedge clk);
                #($urandom_range(2, 40));
                if ($urandom_range(0, 2) == 0) level = ~level;
                #1 check_all();
                if ($urandom_range(0, 7) == 0) begin
                    level = ~level;
                    #1 check_all();
                end
                if ($urandom_range(0, 19) == 0) begin
                    rst_n = 1'b0;
                    #1 check_all();
                    rst_n = 1'b1;
                    #1 check_all();
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/edge_detect_gate.md
# edge_detect_gate

Gate-level (Mealy) rising-edge detector: it compares the live `level_amisha` input against a one-cycle-delayed copy and emits `tick_amisha` while the input is high but the stored copy is still low. It sits behind slow level signals such as buttons, flags and status lines and produces a single-cycle-or-shorter pulse for the downstream FSMs in the chapter's designs. Parameters add an optional input synchronizer and a selectable edge polarity. Defaults reproduce the plain rising-edge gate.

## Interface
Parameters:
- `SYNC_STAGES`, default 0: number of flip-flop synchronizer stages ahead of the detector. Legal range 0..3; 0 means `level_amisha` feeds the gate directly.
- `EDGE_MODE`, default 0: 0 = rising, 1 = falling, 2 = both edges. Values 3 and above behave as 0.

Ports:
- `clk_amisha`, input, 1 bit: the single clock. All flops update on the rising edge.
- `reset_amisha`, input, 1 bit: asynchronous, active-low reset. It clears all flops immediately and forces `tick_amisha` low.
- `level_amisha`, input, 1 bit: level to monitor.
- `tick_amisha`, output, 1 bit: edge pulse, combinational from the gate.

## Operation
- Signal `s` is the sampled level. With `SYNC_STAGES`=0, `s` is `level_amisha`. Otherwise `s` is the output of a chain of `SYNC_STAGES` flops clocked by `clk_amisha`, all cleared by reset.
- Register `delay_reg` is loaded with `s` on every rising clock edge. Reset value is 0.
- Tick logic, gated by the reset input:
  - Mode 0: `tick_amisha` = `s` AND NOT `delay_reg`.
  - Mode 1: `tick_amisha` = NOT `s` AND `delay_reg`.
  - Mode 2: `tick_amisha` = `s` XOR `delay_reg`.
  - In all modes `tick_amisha` is 0 while `reset_amisha` = 0.
- No state machine beyond `delay_reg`, conceptually state ZERO (`delay_reg`=0) or ONE (`delay_reg`=1). The next state is always `s`.
- Reset values:
  - `delay_reg` = 0, all synchronizer flops = 0, `tick_amisha` = 0.
  - After reset release with level already high, mode 0 emits one tick, because `delay_reg` starts at 0.
- No other outputs and no handshake.

## Timing
- `SYNC_STAGES`=0:
  - `tick_amisha` rises combinationally with the qualifying edge of `level_amisha`, with zero-cycle latency.
  - It falls at the next rising clock edge, when `delay_reg` catches up.
  - Pulse width is from the input edge to the next rising clock edge, at most one clock period.
  - Example: level rising mid-cycle gives a half-period pulse.
- `SYNC_STAGES`=N>0:
  - `tick_amisha` asserts N clock edges after the input change is first sampled.
  - It stays high for exactly one full clock period, since it is now glitch-free and registered-source.
- Input pulse narrower than one period with `SYNC_STAGES`=0:
  - Tick follows the input high time if the pulse falls before a clock edge.
  - If no clock edge occurs while it is high, `delay_reg` never sees it.
- Level held constant: tick stays 0 indefinitely.
- Reset asserted mid-pulse: tick drops immediately and asynchronously; `delay_reg` clears.
- Reset release with level=1, mode 0, `SYNC_STAGES`=0: tick = 1 from release until the first rising clock edge.
- Back-to-back edges in consecutive cycles (mode 2): one tick per edge, no merging beyond combinational adjacency.

## Test plan
All scenarios use a 100 ns clock (toggling every 50 ns, first rising edge at 50 ns), `SYNC_STAGES`=0 and `EDGE_MODE`=0 unless stated.
- Reset low 0–100 ns with level=0, then release: tick=0 throughout, `delay_reg`=0.
- Level 0→1 at 200 ns: tick=1 from 200 ns to the rising edge at 250 ns, then 0 while level stays 1.
- Level 1→0 at 300 ns, then 0→1 at 400 ns: no tick at 300 ns; tick=1 from 400 ns to 450 ns.
- Reset pulled low at 420 ns while tick=1: tick=0 immediately; after release with level=1, tick=1 until the next rising edge.
- `EDGE_MODE`=2, level toggles at 200/300/400 ns: tick high 200–250, 300–350 and 400–450 ns.
- `SYNC_STAGES`=2, level 0→1 at 200 ns: tick=1 exactly from the 350 ns edge to the 450 ns edge, glitch-free.
